qtable_best_hop: RTL

- Read-side companion of the Q-table update logic: scans the neighbor table in shared node memory and selects the neighbor with the highest Q-value as the next hop.
- Optionally restricts the candidates to neighbors in the node's own cluster.
- Sits beside the Q-table updater on the same 11-bit address / 16-bit word memory port and is used by the packet-forwarding control.
- Read-only: never drives write enable.

---
 rtl/qtable_best_hop_if.sv | 16 +
 rtl/qtable_best_hop.sv | 129 ++++++++++++
 2 files changed

// File: rtl/qtable_best_hop_if.sv
// Memory read port shared with the Q-table updater.
// 11-bit word address out, 16-bit read data back one cycle later.
interface qtable_best_hop_if;
   logic [10:0] address;
   logic [15:0] data_in;

   modport master (
      output address,
      input  data_in
   );

   modport slave (
      input  address,
      output data_in
   );
endinterface

// File: rtl/qtable_best_hop.sv
// Next-hop selector: scans the neighbor table and keeps the
// neighbor with the highest Q-value, optionally same-cluster only.
module qtable_best_hop #(
   parameter logic [10:0] NCOUNT_ADDR   = 11'h274,
   parameter logic [10:0] NID_BASE      = 11'h100,
   parameter logic [10:0] NQ_BASE       = 11'h180,
   parameter logic [10:0] NCID_BASE     = 11'h200,
   parameter int          MAX_NEIGHBORS = 64
) (
   input  logic               clock,
   input  logic               nrst,
   input  logic               en,
   input  logic               start,
   input  logic               filter_en,
   input  logic [15:0]        my_cid,
   qtable_best_hop_if.master  mem,
   output logic [15:0]        best_id,
   output logic [15:0]        best_q,
   output logic               best_valid,
   output logic               busy,
   output logic               done
);
   localparam int CW = $clog2(MAX_NEIGHBORS + 1);
   localparam logic [15:0]   MAX_W = 16'(MAX_NEIGHBORS);
   localparam logic [CW-1:0] MAX_C = CW'(MAX_NEIGHBORS);

   typedef enum logic [2:0] {
      IDLE, S_CNT, S_ID, S_Q, S_CID, S_DONE
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] idx;
   logic [CW-1:0] cnt_clamp;
   logic [CW-1:0] idx_nxt;
   logic          filt_q;
   logic [15:0]   cid_q;
   logic [15:0]   cur_id;
   logic [15:0]   cur_q;
   logic          eligible;
   logic          better;

   // Clamp, next index and candidate qualification.
   // best_valid doubles as the "found" flag: they always agree.
   always_comb begin
      cnt_clamp = (mem.data_in > MAX_W) ? MAX_C
                                        : mem.data_in[CW-1:0];
      idx_nxt   = idx + CW'(1);
      eligible  = !filt_q || (mem.data_in == cid_q);
      better    = !best_valid || (cur_q > best_q);
   end

   // Scan FSM: count, then ID / Q / cluster-ID per entry.
   always_ff @(posedge clock) begin
      if (!nrst) begin
         state       <= IDLE;
         mem.address <= '0;
         best_id     <= '0;
         best_q      <= '0;
         best_valid  <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         cnt         <= '0;
         idx         <= '0;
         filt_q      <= 1'b0;
         cid_q       <= '0;
         cur_id      <= '0;
         cur_q       <= '0;
      end else if (en) begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  filt_q      <= filter_en;
                  cid_q       <= my_cid;
                  best_id     <= '0;
                  best_q      <= '0;
                  best_valid  <= 1'b0;
                  mem.address <= NCOUNT_ADDR;
                  busy        <= 1'b1;
                  state       <= S_CNT;
               end
            end
            S_CNT: begin
               cnt <= cnt_clamp;
               idx <= '0;
               if (cnt_clamp == '0) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  mem.address <= NID_BASE;
                  state       <= S_ID;
               end
            end
            S_ID: begin
               cur_id      <= mem.data_in;
               mem.address <= NQ_BASE + 11'(idx);
               state       <= S_Q;
            end
            S_Q: begin
               cur_q       <= mem.data_in;
               mem.address <= NCID_BASE + 11'(idx);
               state       <= S_CID;
            end
            S_CID: begin
               // Strict compare: ties keep the lower index.
               if (eligible && better) begin
                  best_id    <= cur_id;
                  best_q     <= cur_q;
                  best_valid <= 1'b1;
               end
               if (idx_nxt == cnt) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  idx         <= idx_nxt;
                  mem.address <= NID_BASE + 11'(idx_nxt);
                  state       <= S_ID;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
